// File: rtl/mod_m_step_counter.sv
// Purpose: runtime-programmable mod-M step counter with double-buffered modulus/step.
// Latency: q updates one clk after en/clr; max_tick is combinational; cfg_pend/cfg_err are registered.
// Backpressure: none; en gates advance and q holds while en=0. The config update is a one-cycle cfg_wr strobe.
module mod_m_step_counter #(
  parameter int N            = 16,
  parameter int M_DEFAULT    = 10,
  parameter int STEP_DEFAULT = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  input  logic         dir,
  input  logic         cfg_wr,
  input  logic [N-1:0] cfg_m,
  input  logic [N-1:0] cfg_step,
  output logic [N-1:0] q,
  output logic         max_tick,
  output logic         cfg_pend,
  output logic         cfg_err
);

  localparam logic [N-1:0] M_DEF    = N'(M_DEFAULT);
  localparam logic [N-1:0] STEP_DEF = N'(STEP_DEFAULT);

  // Active configuration and the shadow copy waiting to be applied.
  logic [N-1:0] m_act, step_act;
  logic [N-1:0] m_shd, step_shd;

  // Next-state values.
  logic [N-1:0] q_nxt, m_act_nxt, step_act_nxt, m_shd_nxt, step_shd_nxt;
  logic         cfg_pend_nxt, cfg_err_nxt;

  // A write is accepted only if it keeps the invariant q < M reachable (M>=1, step<M).
  logic cfg_ok;
  assign cfg_ok = cfg_wr && (cfg_m != '0) && (cfg_step < cfg_m);

  // Up-count sum is one bit wider so q+step never aliases past M.
  logic [N:0]   sum_up;
  logic         wrap_up, wrap_dn, wrap;
  logic [N-1:0] up_wrap_q, dn_wrap_q, q_adv;

  assign sum_up    = {1'b0, q} + {1'b0, step_act};
  assign wrap_up   = (sum_up >= {1'b0, m_act});
  assign wrap_dn   = (q < step_act);
  assign wrap      = dir ? wrap_dn : wrap_up;
  assign up_wrap_q = N'(sum_up - {1'b0, m_act});
  assign dn_wrap_q = N'({1'b0, q} + {1'b0, m_act} - {1'b0, step_act});

  // With step 0 neither wrap condition can be true, so q simply holds.
  assign max_tick = en & wrap;

  // Advanced count for one enabled edge when no pending config is applied.
  always_comb begin
    q_adv = q;
    if (dir) begin
      q_adv = wrap_dn ? dn_wrap_q : (q - step_act);
    end else begin
      q_adv = wrap_up ? up_wrap_q : sum_up[N-1:0];
    end
  end

  // Next-state: clr beats en; a pending shadow is applied on clr or on an enabled wrap.
  always_comb begin
    q_nxt        = q;
    m_act_nxt    = m_act;
    step_act_nxt = step_act;
    m_shd_nxt    = m_shd;
    step_shd_nxt = step_shd;
    cfg_pend_nxt = cfg_pend;
    cfg_err_nxt  = cfg_wr & ~cfg_ok;

    if (clr) begin
      q_nxt = '0;
      if (cfg_ok) begin
        // Same-cycle write bypasses the shadow and goes live immediately.
        m_act_nxt    = cfg_m;
        step_act_nxt = cfg_step;
        m_shd_nxt    = cfg_m;
        step_shd_nxt = cfg_step;
        cfg_pend_nxt = 1'b0;
      end else if (cfg_pend) begin
        m_act_nxt    = m_shd;
        step_act_nxt = step_shd;
        cfg_pend_nxt = 1'b0;
      end
    end else begin
      if (en) begin
        if (wrap && cfg_pend) begin
          // New config restarts the sequence from 0 in either direction.
          q_nxt        = '0;
          m_act_nxt    = m_shd;
          step_act_nxt = step_shd;
          cfg_pend_nxt = 1'b0;
        end else begin
          q_nxt = q_adv;
        end
      end
      // A write landing on the apply edge is captured after the old shadow leaves.
      if (cfg_ok) begin
        m_shd_nxt    = cfg_m;
        step_shd_nxt = cfg_step;
        cfg_pend_nxt = 1'b1;
      end
    end
  end

  // State registers with asynchronous reset to the default configuration.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q        <= '0;
      m_act    <= M_DEF;
      step_act <= STEP_DEF;
      m_shd    <= M_DEF;
      step_shd <= STEP_DEF;
      cfg_pend <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      q        <= q_nxt;
      m_act    <= m_act_nxt;
      step_act <= step_act_nxt;
      m_shd    <= m_shd_nxt;
      step_shd <= step_shd_nxt;
      cfg_pend <= cfg_pend_nxt;
      cfg_err  <= cfg_err_nxt;
    end
  end

endmodule

// File: doc/mod_m_step_counter.md
Name: mod_m_step_counter

Overview:
Runtime-programmable mod-M counter/accumulator for the DDS datapath.
- Each enabled cycle, adds or subtracts a programmable step modulo a programmable modulus M.
- Used as a phase index generator and as a programmable tick/prescaler source.
- Modulus and step are double-buffered: a new configuration takes effect only at a wrap or on a synchronous clear, so the sequence never glitches.

Parameters:
N, 16, counter/config width in bits.
M_DEFAULT, 10, active modulus after reset; legal range 1..2^N-1.
STEP_DEFAULT, 1, active step after reset; must be < M_DEFAULT.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-high reset.
en  in  1  count enable; q advances by one step per cycle while high.
clr  in  1  synchronous clear; q<=0 and any pending config is applied.
dir  in  1  0 = count up (add step), 1 = count down (subtract step).
cfg_wr  in  1  one-cycle strobe; captures cfg_m/cfg_step into the shadow registers.
cfg_m  in  N  requested modulus.
cfg_step  in  N  requested step.
q  out  N  current count; always < active modulus.
max_tick  out  1  combinational; high when en=1 and the next edge wraps q.
cfg_pend  out  1  registered; shadow config is waiting to be applied.
cfg_err  out  1  registered one-cycle pulse; the last cfg_wr was rejected.

Behaviour:
- Reset (async, highest priority) sets:
  - q=0, m_act=M_DEFAULT, step_act=STEP_DEFAULT.
  - Shadow registers = defaults, cfg_pend=0, cfg_err=0.
  - max_tick then follows its combinational definition.
- Priority per edge: reset > clr > en. With en=0 and clr=0, q holds.
- Config validation on cfg_wr:
  - Valid iff cfg_m>=1 and cfg_step<cfg_m.
  - Valid: shadow<=cfg_m/cfg_step, cfg_pend<=1. A later valid write overwrites the shadow (last write wins).
  - Invalid: shadow unchanged, cfg_pend unchanged, cfg_err=1 for exactly one cycle.
- Up count (dir=0): sum=q+step_act, computed in N+1 bits.
  - sum>=m_act: wrap, q<=sum-m_act.
  - Otherwise q<=sum.
- Down count (dir=1):
  - q>=step_act: q<=q-step_act.
  - Otherwise: wrap, q<=q+m_act-step_act, computed in N+1 bits.
- max_tick = en & wrap condition (up: q+step_act>=m_act; down: q<step_act). It is 0 whenever en=0. With step=1 up, it is high while q=m_act-1.
- Apply on wrap: if an enabled wrap occurs while cfg_pend=1, then on that edge:
  - m_act<=shadow m, step_act<=shadow step.
  - q<=0 (restart, both directions).
  - cfg_pend<=0.
- Apply on clr: q<=0. If cfg_pend=1, the shadow is applied and cfg_pend<=0.
- Simultaneous events:
  - clr with a valid cfg_wr in the same cycle: the new values go directly to m_act/step_act, q<=0, cfg_pend<=0.
  - Wrap with a valid cfg_wr in the same cycle: the wrap applies the existing shadow (if pending); the new write is captured and cfg_pend<=1.
- dir changes take effect on the next enabled edge; a direction change causes no wrap or clear by itself.
- step_act=0: q holds while enabled, max_tick=0; only clr applies a pending config.
- m_act=1: q stays 0. With step 0 in this case, no wrap occurs.
- Invariant: q<m_act on every cycle; the bench asserts it.

Test Plan:
- Defaults, N=4, M=10, step=1, dir=0, en=1 for 25 cycles -> q=0..9,0..9,0..4; max_tick high only while q=9 (cycles 9 and 19).
- cfg_wr m=10/step=3 then clr, dir=0, en=1 -> q=0,3,6,9,2,5,8,1,4,7,0; max_tick high at q=9,8,7.
- Same config, dir=1 -> q=0,7,4,1,8,5,2,9,6,3,0; max_tick high at q=0,1,2.
- M=10, step=1, q=4: cfg_wr m=5/step=1 -> cfg_pend=1; q continues 5..9, then 0 with m_act=5, cfg_pend=0; then q=0..4,0.
- cfg_wr m=4/step=4, then cfg_wr m=0/step=0 -> each gives a one-cycle cfg_err pulse; cfg_pend and the counting sequence are unaffected.
- Mid-count q=6: assert reset between edges -> q=0 immediately, m_act back to 10. Then en=0, clr=1 at q=3 -> q=0 on the next edge.
